// File: rtl/parking_gate_controller.sv
// Parking gate controller: two independent lanes (entry, exit), each with a
// synchronized and debounced loop detector driving a small barrier FSM.
// Entry checks zone vacancy for the latched badge class before opening;
// exit always opens. Strobes and class qualifiers feed the parking counter.

module pgc_sensor_filter #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_arrive,
  output logic o_depart
);
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic [CW-1:0] r_cnt;
  logic          w_flip;

  // The debounced state flips on the DEBOUNCE-th consecutive differing sample;
  // arrival/departure are reported in that same edge so the FSM reacts at once.
  assign w_flip   = (r_sync2 != r_db) && (r_cnt == CNT_LAST);
  assign o_arrive = w_flip & r_sync2;
  assign o_depart = w_flip & ~r_sync2;

  // Two-flop synchronizer followed by a run-length debouncer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= {CW{1'b0}};
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_db) begin
        if (r_cnt == CNT_LAST) begin
          r_db  <= r_sync2;
          r_cnt <= {CW{1'b0}};
        end else begin
          r_cnt <= r_cnt + CW'(1'b1);
        end
      end else begin
        r_cnt <= {CW{1'b0}};
      end
    end
  end
endmodule

module parking_gate_controller #(
  parameter int DEBOUNCE = 3,
  parameter int HOLD     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic entry_sensor,
  input  logic entry_badge_uni,
  input  logic exit_sensor,
  input  logic exit_badge_uni,
  input  logic uni_is_vacated_space,
  input  logic is_vacated_space,
  output logic entry_barrier_open,
  output logic exit_barrier_open,
  output logic entry_denied,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic car_exited,
  output logic is_uni_car_exited
);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [2:0] {
    E_IDLE      = 3'd0,
    E_CHECK     = 3'd1,
    E_OPEN      = 3'd2,
    E_HOLD_OPEN = 3'd3,
    E_DENY      = 3'd4
  } entry_state_t;

  typedef enum logic [1:0] {
    X_IDLE      = 2'd0,
    X_OPEN      = 2'd1,
    X_HOLD_OPEN = 2'd2
  } exit_state_t;

  logic w_e_arrive;
  logic w_e_depart;
  logic w_x_arrive;
  logic w_x_depart;

  entry_state_t  r_e_state;
  logic          r_e_class;
  logic [HW-1:0] r_e_hold;
  logic          r_e_barrier;
  logic          r_e_denied;
  logic          r_e_strobe;
  logic          r_e_qual;

  exit_state_t   r_x_state;
  logic          r_x_class;
  logic [HW-1:0] r_x_hold;
  logic          r_x_barrier;
  logic          r_x_strobe;
  logic          r_x_qual;

  pgc_sensor_filter #(.DEBOUNCE(DEBOUNCE)) u_entry_filter (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (entry_sensor),
    .o_arrive (w_e_arrive),
    .o_depart (w_e_depart)
  );

  pgc_sensor_filter #(.DEBOUNCE(DEBOUNCE)) u_exit_filter (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (exit_sensor),
    .o_arrive (w_x_arrive),
    .o_depart (w_x_depart)
  );

  // Entry lane: latch class on arrival, check vacancy once, open or refuse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_e_state   <= E_IDLE;
      r_e_class   <= 1'b0;
      r_e_hold    <= {HW{1'b0}};
      r_e_barrier <= 1'b0;
      r_e_denied  <= 1'b0;
      r_e_strobe  <= 1'b0;
      r_e_qual    <= 1'b0;
    end else begin
      r_e_denied <= 1'b0;
      r_e_strobe <= 1'b0;
      case (r_e_state)
        E_IDLE: begin
          if (w_e_arrive) begin
            r_e_class <= entry_badge_uni;
            r_e_state <= E_CHECK;
          end
        end
        E_CHECK: begin
          // Vacancy is only looked at here; later changes cannot close the gate
          if (r_e_class ? uni_is_vacated_space : is_vacated_space) begin
            r_e_barrier <= 1'b1;
            r_e_state   <= E_OPEN;
          end else begin
            r_e_denied <= 1'b1;
            r_e_state  <= E_DENY;
          end
        end
        E_OPEN: begin
          if (w_e_depart) begin
            r_e_strobe <= 1'b1;
            r_e_qual   <= r_e_class;
            r_e_hold   <= {HW{1'b0}};
            r_e_state  <= E_HOLD_OPEN;
          end
        end
        E_HOLD_OPEN: begin
          if (r_e_hold == HOLD_LAST) begin
            r_e_barrier <= 1'b0;
            r_e_state   <= E_IDLE;
          end else begin
            r_e_hold <= r_e_hold + HW'(1'b1);
          end
        end
        E_DENY: begin
          if (w_e_depart) begin
            r_e_state <= E_IDLE;
          end
        end
        default: begin
          r_e_barrier <= 1'b0;
          r_e_state   <= E_IDLE;
        end
      endcase
    end
  end

  // Exit lane: always opens on arrival, counts the car out on departure
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_state   <= X_IDLE;
      r_x_class   <= 1'b0;
      r_x_hold    <= {HW{1'b0}};
      r_x_barrier <= 1'b0;
      r_x_strobe  <= 1'b0;
      r_x_qual    <= 1'b0;
    end else begin
      r_x_strobe <= 1'b0;
      case (r_x_state)
        X_IDLE: begin
          if (w_x_arrive) begin
            r_x_class   <= exit_badge_uni;
            r_x_barrier <= 1'b1;
            r_x_state   <= X_OPEN;
          end
        end
        X_OPEN: begin
          if (w_x_depart) begin
            r_x_strobe <= 1'b1;
            r_x_qual   <= r_x_class;
            r_x_hold   <= {HW{1'b0}};
            r_x_state  <= X_HOLD_OPEN;
          end
        end
        X_HOLD_OPEN: begin
          if (r_x_hold == HOLD_LAST) begin
            r_x_barrier <= 1'b0;
            r_x_state   <= X_IDLE;
          end else begin
            r_x_hold <= r_x_hold + HW'(1'b1);
          end
        end
        default: begin
          r_x_barrier <= 1'b0;
          r_x_state   <= X_IDLE;
        end
      endcase
    end
  end

  assign entry_barrier_open = r_e_barrier;
  assign entry_denied       = r_e_denied;
  assign car_entered        = r_e_strobe;
  assign is_uni_car_entered = r_e_qual;
  assign exit_barrier_open  = r_x_barrier;
  assign car_exited         = r_x_strobe;
  assign is_uni_car_exited  = r_x_qual;
endmodule

// File: tb/tb_parking_gate_controller.sv
// Self-checking bench for parking_gate_controller: scenario tasks plus a
// randomized traffic run, all compared against a behavioural lane model.

module tb_parking_gate_controller;
  localparam int DEBOUNCE = 3;
  localparam int HOLD     = 4;
  localparam int LAT      = 2 + DEBOUNCE + 1;

  logic clk = 1'b0;
  logic rst, entry_sensor, entry_badge_uni, exit_sensor, exit_badge_uni;
  logic uni_is_vacated_space, is_vacated_space;
  logic entry_barrier_open, exit_barrier_open, entry_denied;
  logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  parking_gate_controller #(.DEBOUNCE(DEBOUNCE), .HOLD(HOLD)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .entry_sensor         (entry_sensor),
    .entry_badge_uni      (entry_badge_uni),
    .exit_sensor          (exit_sensor),
    .exit_badge_uni       (exit_badge_uni),
    .uni_is_vacated_space (uni_is_vacated_space),
    .is_vacated_space     (is_vacated_space),
    .entry_barrier_open   (entry_barrier_open),
    .exit_barrier_open    (exit_barrier_open),
    .entry_denied         (entry_denied),
    .car_entered          (car_entered),
    .is_uni_car_entered   (is_uni_car_entered),
    .car_exited           (car_exited),
    .is_uni_car_exited    (is_uni_car_exited)
  );

  always #5 clk = ~clk;

  // {entry gate, denied, car_entered, uni_in, exit gate, car_exited, uni_out}
  logic [6:0] obs;
  logic [6:0] exp_v = 7'b0;
  assign obs = {entry_barrier_open, entry_denied, car_entered, is_uni_car_entered,
                exit_barrier_open, car_exited, is_uni_car_exited};

  // ---------------- behavioural model ----------------
  bit [1:0] m_e_hist, m_x_hist;
  bit m_e_db, m_x_db;
  int m_e_run, m_x_run;
  bit m_e_check, m_e_wait, m_e_refused, m_e_cls, m_e_gate, m_e_deny, m_e_str, m_e_q;
  int m_e_hold;
  bit m_x_wait, m_x_cls, m_x_gate, m_x_str, m_x_q;
  int m_x_hold;

  // A sensor change counts once DEBOUNCE samples, each seen two edges late, disagree with the held state
  task automatic filt(input bit s, inout bit [1:0] hist, inout bit db, inout int run,
                      output bit arr, output bit dep);
    bit smp;
    smp  = hist[1];
    hist = {hist[0], s};
    arr  = 1'b0;
    dep  = 1'b0;
    if (smp != db) run++; else run = 0;
    if (run == DEBOUNCE) begin
      db  = smp;
      run = 0;
      arr = smp;
      dep = !smp;
    end
  endtask

  task automatic model_edge();
    bit ea, ed, xa, xd;
    if (rst) begin
      m_e_hist = 2'b0; m_x_hist = 2'b0; m_e_db = 0; m_x_db = 0; m_e_run = 0; m_x_run = 0;
      m_e_check = 0; m_e_wait = 0; m_e_refused = 0; m_e_cls = 0; m_e_gate = 0;
      m_e_deny = 0; m_e_str = 0; m_e_q = 0; m_e_hold = 0;
      m_x_wait = 0; m_x_cls = 0; m_x_gate = 0; m_x_str = 0; m_x_q = 0; m_x_hold = 0;
    end else begin
      filt(entry_sensor, m_e_hist, m_e_db, m_e_run, ea, ed);
      filt(exit_sensor, m_x_hist, m_x_db, m_x_run, xa, xd);
      m_e_str = 0; m_e_deny = 0;
      if (m_e_hold > 0) begin
        m_e_hold--;
        if (m_e_hold == 0) m_e_gate = 0;
      end else if (m_e_check) begin
        m_e_check = 0;
        if (m_e_cls ? uni_is_vacated_space : is_vacated_space) begin
          m_e_gate = 1; m_e_wait = 1;
        end else begin
          m_e_deny = 1; m_e_refused = 1;
        end
      end else if (m_e_wait) begin
        if (ed) begin m_e_wait = 0; m_e_str = 1; m_e_q = m_e_cls; m_e_hold = HOLD; end
      end else if (m_e_refused) begin
        if (ed) m_e_refused = 0;
      end else if (ea) begin
        m_e_check = 1; m_e_cls = entry_badge_uni;
      end
      m_x_str = 0;
      if (m_x_hold > 0) begin
        m_x_hold--;
        if (m_x_hold == 0) m_x_gate = 0;
      end else if (m_x_wait) begin
        if (xd) begin m_x_wait = 0; m_x_str = 1; m_x_q = m_x_cls; m_x_hold = HOLD; end
      end else if (xa) begin
        m_x_wait = 1; m_x_gate = 1; m_x_cls = exit_badge_uni;
      end
    end
    exp_v = {m_e_gate, m_e_deny, m_e_str, m_e_q, m_x_gate, m_x_str, m_x_q};
  endtask

  // Advance model and DUT by one clock; outputs are then read at the falling edge
  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1; entry_sensor = 0; exit_sensor = 0; entry_badge_uni = 0; exit_badge_uni = 0;
    uni_is_vacated_space = 0; is_vacated_space = 0;
    cycle(); cycle();
    checks++;
    if (obs !== 7'b0) begin errors++; $display("FAIL reset_outputs obs=%b exp=%b", obs, 7'b0); end
    rst = 0;
    for (int t = 0; t < 5; t++) begin
      cycle(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL reset_idle cyc=%0d obs=%b exp=%b", cyc, obs, exp_v); end
    end
  endtask

  task automatic test_public_entry();
    int first_up = -1, strobe_at = -1, down_at = -1, n_str = 0;
    bit q = 1'b1;
    entry_badge_uni = 0; is_vacated_space = 1; uni_is_vacated_space = 1'($urandom_range(0, 1));
    entry_sensor = 1;
    for (int t = 1; t <= 45; t++) begin
      if (t == 10) is_vacated_space = 0;
      if (t == 21) entry_sensor = 0;
      cycle(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL public_entry cyc=%0d obs=%b exp=%b", cyc, obs, exp_v); end
      if (entry_barrier_open && first_up < 0) first_up = t;
      if (car_entered) begin n_str++; strobe_at = t; q = is_uni_car_entered; end
      if (!entry_barrier_open && first_up >= 0 && down_at < 0) down_at = t;
    end
    checks++;
    if (first_up != LAT) begin errors++; $display("FAIL public_latency got=%0d want=%0d", first_up, LAT); end
    checks++;
    if (n_str != 1) begin errors++; $display("FAIL public_strobes got=%0d want=1", n_str); end
    checks++;
    if (q !== 1'b0) begin errors++; $display("FAIL public_qualifier got=%b want=0", q); end
    checks++;
    if (down_at - strobe_at != HOLD) begin errors++; $display("FAIL public_hold got=%0d want=%0d", down_at - strobe_at, HOLD); end
  endtask

  task automatic test_uni_denied();
    int n_deny = 0, deny_at = -1, n_up = 0, n_str = 0;
    entry_badge_uni = 1; uni_is_vacated_space = 0; is_vacated_space = 1;
    entry_sensor = 1;
    for (int t = 1; t <= 30; t++) begin
      if (t == 16) entry_sensor = 0;
      cycle(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL uni_denied cyc=%0d obs=%b exp=%b", cyc, obs, exp_v); end
      if (entry_denied) begin n_deny++; deny_at = t; end
      if (entry_barrier_open) n_up++;
      if (car_entered) n_str++;
    end
    checks++;
    if (n_deny != 1 || deny_at != LAT) begin errors++; $display("FAIL deny_pulse count=%0d at=%0d want 1 at %0d", n_deny, deny_at, LAT); end
    checks++;
    if (n_up != 0 || n_str != 0) begin errors++; $display("FAIL deny_closed up=%0d strobes=%0d want 0", n_up, n_str); end
  endtask

  task automatic test_bounce();
    int active = 0;
    for (int t = 1; t <= 22; t++) begin
      entry_sensor = (t <= 10) ? t[0] : 1'b0;
      exit_sensor  = (t <= 10) ? ~t[0] : 1'b0;
      cycle(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL bounce cyc=%0d obs=%b exp=%b", cyc, obs, exp_v); end
      if ((obs & 7'b1110110) != 7'b0) active++;
    end
    checks++;
    if (active != 0) begin errors++; $display("FAIL bounce_quiet active_cycles=%0d want=0", active); end
  endtask

  task automatic test_simultaneous();
    int len, e_at = -1, x_at = -1, x_up = -1;
    bit qe = 1'b0, qx = 1'b1;
    len = $urandom_range(10, 20);
    entry_badge_uni = 1; uni_is_vacated_space = 1; is_vacated_space = 1'($urandom_range(0, 1));
    exit_badge_uni = 0;
    entry_sensor = 1; exit_sensor = 1;
    for (int t = 1; t <= len + 20; t++) begin
      if (t == len + 1) begin entry_sensor = 0; exit_sensor = 0; end
      cycle(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL simultaneous cyc=%0d obs=%b exp=%b", cyc, obs, exp_v); end
      if (exit_barrier_open && x_up < 0) x_up = t;
      if (car_entered) begin e_at = t; qe = is_uni_car_entered; end
      if (car_exited) begin x_at = t; qx = is_uni_car_exited; end
    end
    checks++;
    if (e_at < 0 || e_at != x_at) begin errors++; $display("FAIL simul_strobes entered_at=%0d exited_at=%0d want equal", e_at, x_at); end
    checks++;
    if (qe !== 1'b1 || qx !== 1'b0) begin errors++; $display("FAIL simul_qualifiers got=%b%b want=10", qe, qx); end
    checks++;
    if (x_up != LAT - 1) begin errors++; $display("FAIL exit_latency got=%0d want=%0d", x_up, LAT - 1); end
  endtask

  task automatic test_reset_in_open();
    int t_up = -1, n_str = 0;
    entry_badge_uni = 1'($urandom_range(0, 1)); uni_is_vacated_space = 1; is_vacated_space = 1;
    entry_sensor = 1;
    for (int t = 1; t <= 20 && t_up < 0; t++) begin
      cycle(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rst_open_pre cyc=%0d obs=%b exp=%b", cyc, obs, exp_v); end
      if (entry_barrier_open) t_up = t;
    end
    checks++;
    if (t_up < 0) begin errors++; $display("FAIL rst_open_timeout barrier=0 want=1 within 20 cycles"); end
    cycle(); cycle();
    rst = 1;
    cycle();
    rst = 0;
    checks++;
    if ({entry_barrier_open, car_entered, is_uni_car_entered} !== 3'b000) begin
      errors++; $display("FAIL rst_open_close got=%b want=000", {entry_barrier_open, car_entered, is_uni_car_entered});
    end
    t_up = -1;
    for (int t = 1; t <= 20 && t_up < 0; t++) begin
      cycle(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rst_open_re cyc=%0d obs=%b exp=%b", cyc, obs, exp_v); end
      if (car_entered) n_str++;
      if (entry_barrier_open) t_up = t;
    end
    checks++;
    if (t_up != LAT) begin errors++; $display("FAIL rst_rearrival got=%0d want=%0d", t_up, LAT); end
    entry_sensor = 0;
    for (int t = 1; t <= 20; t++) begin
      cycle(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rst_open_post cyc=%0d obs=%b exp=%b", cyc, obs, exp_v); end
      if (car_entered) n_str++;
    end
    checks++;
    if (n_str != 1) begin errors++; $display("FAIL rst_open_strobes got=%0d want=1", n_str); end
  endtask

  task automatic test_back_to_back();
    int n_str = 0, n_uni = 0, want_uni = 0, gaps = 0;
    bit closed;
    for (int v = 0; v < 5; v++) begin
      exit_badge_uni = 1'($urandom_range(0, 1));
      want_uni += int'(exit_badge_uni);
      closed = 1'b0;
      for (int t = 0; t < 18; t++) begin
        exit_sensor = (t < 8);
        cycle(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL back_to_back cyc=%0d obs=%b exp=%b", cyc, obs, exp_v); end
        if (car_exited) begin n_str++; n_uni += int'(is_uni_car_exited); end
        if (t >= 8 && !exit_barrier_open) closed = 1'b1;
      end
      if (closed) gaps++;
    end
    checks++;
    if (n_str != 5) begin errors++; $display("FAIL b2b_count got=%0d want=5", n_str); end
    checks++;
    if (n_uni != want_uni) begin errors++; $display("FAIL b2b_uni got=%0d want=%0d", n_uni, want_uni); end
    checks++;
    if (gaps != 5) begin errors++; $display("FAIL b2b_gaps got=%0d want=5", gaps); end
  endtask

  task automatic test_random();
    int e_left = 0, x_left = 0;
    for (int t = 0; t < 4000; t++) begin
      if (e_left == 0) begin entry_sensor = ~entry_sensor; e_left = $urandom_range(1, 15); end
      if (x_left == 0) begin exit_sensor = ~exit_sensor; x_left = $urandom_range(1, 15); end
      e_left--; x_left--;
      if ($urandom_range(0, 7) == 0) entry_badge_uni = ~entry_badge_uni;
      if ($urandom_range(0, 7) == 0) exit_badge_uni = ~exit_badge_uni;
      uni_is_vacated_space = 1'($urandom_range(0, 1));
      is_vacated_space     = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 299) == 0);
      cycle(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random cyc=%0d obs=%b exp=%b", cyc, obs, exp_v); end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_public_entry();
    test_uni_denied();
    test_bounce();
    test_simultaneous();
    test_reset_in_open();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
